rsqrt_share_arb: RTL and testbench

- Shares one pipelined FP16 reciprocal-square-root core among NUM_REQ requesters in the LayerNorm SFU, e.g. per-lane variance-to-scale paths.
- Round-robin arbitrates valid/ready requests and issues at most one operand per cycle to the core.
- Tracks each in-flight operation with a tag pipeline matched to the core latency.
- Steers each result into a per-requester response register held until that requester accepts it.

---
 rtl/rsqrt_share_arb.sv | 127 ++++++++++++
 tb/tb_rsqrt_share_arb.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rsqrt_share_arb.sv
// Round-robin sharing of one fixed-latency FP16 rsqrt core among NUM_REQ requesters.
// A tag pipeline steers each result back to a response register held until accepted.
module rsqrt_share_arb #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16,
    parameter int LATENCY = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         resp_valid,
    input  logic [NUM_REQ-1:0]         resp_ready,
    output logic [NUM_REQ*WIDTH-1:0]   resp_data,
    output logic                       core_in_valid,
    output logic [WIDTH-1:0]           core_in_data,
    input  logic                       core_out_valid,
    input  logic [WIDTH-1:0]           core_out_data,
    output logic                       busy,
    output logic                       tag_err
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BW  = $clog2(LATENCY + 1);

    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     gnt_idx;
    logic [IDW:0]       scan;
    logic               found;
    logic [NUM_REQ-1:0] pend;
    logic [NUM_REQ-1:0] pend_nxt;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] resp_hs;
    logic [NUM_REQ-1:0] capture;
    logic [WIDTH-1:0]   gnt_data;
    logic               tag_v  [LATENCY];
    logic [IDW-1:0]     tag_id [LATENCY];
    logic [BW-1:0]      blank_cnt;

    assign eligible = req_valid & ~pend;
    assign resp_hs  = resp_valid & resp_ready;
    assign pend_nxt = (pend | req_ready) & ~resp_hs;

    // Scan from ptr upward with wrap; found also marks a request handshake this cycle.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        scan    = '0;
        for (int o = 0; o < NUM_REQ; o++) begin
            scan = {1'b0, ptr} + (IDW+1)'(o);
            if (scan >= (IDW+1)'(NUM_REQ)) begin
                scan = scan - (IDW+1)'(NUM_REQ);
            end
            if (!found && eligible[scan[IDW-1:0]]) begin
                found   = 1'b1;
                gnt_idx = scan[IDW-1:0];
            end
        end
        if (rst) begin
            found = 1'b0;
        end
    end

    always_comb begin
        req_ready = '0;
        gnt_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (found && gnt_idx == IDW'(i)) begin
                req_ready[i] = 1'b1;
                gnt_data     = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        capture = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (tag_v[LATENCY-1] && tag_id[LATENCY-1] == IDW'(k)) begin
                capture[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr           <= '0;
            pend          <= '0;
            busy          <= 1'b0;
            resp_valid    <= '0;
            resp_data     <= '0;
            core_in_valid <= 1'b0;
            core_in_data  <= '0;
            tag_err       <= 1'b0;
            blank_cnt     <= BW'(LATENCY);
            for (int s = 0; s < LATENCY; s++) begin
                tag_v[s]  <= 1'b0;
                tag_id[s] <= '0;
            end
        end else begin
            pend          <= pend_nxt;
            busy          <= |pend_nxt;
            core_in_valid <= found;
            if (found) begin
                core_in_data <= gnt_data;
                ptr          <= (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
            end
            tag_v[0]  <= found;
            tag_id[0] <= gnt_idx;
            for (int s = 1; s < LATENCY; s++) begin
                tag_v[s]  <= tag_v[s-1];
                tag_id[s] <= tag_id[s-1];
            end
            resp_valid <= (resp_valid & ~resp_hs) | capture;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (capture[k]) begin
                    resp_data[k*WIDTH +: WIDTH] <= core_out_data;
                end
            end
            // Results from ops flushed by reset may still emerge; blank the check meanwhile.
            if (blank_cnt != '0) begin
                blank_cnt <= blank_cnt - BW'(1);
            end else if (core_out_valid != tag_v[LATENCY-1]) begin
                tag_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rsqrt_share_arb.sv
// Directed bench for rsqrt_share_arb with a behavioural rsqrt core (exact powers of four).
module tb_rsqrt_share_arb;
    localparam int N = 4;
    localparam int W = 16;
    localparam int L = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   resp_valid;
    logic [N-1:0]   resp_ready;
    logic [N*W-1:0] resp_data;
    logic           core_in_valid;
    logic [W-1:0]   core_in_data;
    logic           core_out_valid;
    logic [W-1:0]   core_out_data;
    logic           busy;
    logic           tag_err;
    logic           force_ov;

    logic [L-2:0]   cm_v;
    logic [W-1:0]   cm_d [L-1];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rsqrt_share_arb #(.NUM_REQ(N), .WIDTH(W), .LATENCY(L)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .core_in_valid(core_in_valid), .core_in_data(core_in_data),
        .core_out_valid(core_out_valid), .core_out_data(core_out_data),
        .busy(busy), .tag_err(tag_err)
    );

    // 1/sqrt(4^k) for positive, zero-mantissa FP16 values with even unbiased exponent
    function automatic logic [W-1:0] rsqrt_f16(input logic [W-1:0] x);
        int e;
        e = int'(x[14:10]) - 15;
        if (x[15] == 1'b0 && x[9:0] == 10'd0 && x[14:10] != 5'd0 && (e % 2) == 0)
            return {1'b0, 5'(15 - e / 2), 10'd0};
        return 16'h7E00;
    endfunction

    // Result visible LATENCY-1 cycles after core_in_valid, aligned with the last tag stage
    always @(posedge clk) begin
        cm_v[0] <= core_in_valid;
        cm_d[0] <= rsqrt_f16(core_in_data);
        for (int s = 1; s < L - 1; s++) begin
            cm_v[s] <= cm_v[s-1];
            cm_d[s] <= cm_d[s-1];
        end
    end
    assign core_out_valid = cm_v[L-2] | force_ov;
    assign core_out_data  = cm_d[L-2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = '0;
        force_ov   = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    int gl[$];
    int others;

    initial begin
        rst        = 1'b1;
        req_valid  = '1;
        req_data   = '0;
        resp_ready = '0;
        force_ov   = 1'b0;
        step();
        step();
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_core_in_valid", 32'(core_in_valid), 32'h0);
        check("rst_core_in_data", 32'(core_in_data), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_tag_err", 32'(tag_err), 32'h0);
        check("rst_resp_data", 32'(resp_data[31:0]), 32'h0);

        // single request, requester 0, 4.0 -> 0.5
        do_reset();
        req_data[15:0] = 16'h4400;
        req_valid      = 4'b0001;
        #1 check("t1_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        #1;
        check("t1_cin_valid", 32'(core_in_valid), 32'h1);
        check("t1_cin_data", 32'(core_in_data), 32'h4400);
        check("t1_busy", 32'(busy), 32'h1);
        repeat (7) step();
        check("t1_resp_early", 32'(resp_valid), 32'h0);
        step();
        check("t1_resp_valid", 32'(resp_valid), 32'h1);
        check("t1_resp_data", 32'(resp_data[15:0]), 32'h3800);
        resp_ready = 4'b0001;
        step();
        resp_ready = '0;
        check("t1_resp_clear", 32'(resp_valid), 32'h0);
        check("t1_busy_clear", 32'(busy), 32'h0);
        check("t1_cin_idle", 32'(core_in_valid), 32'h0);

        // all four together: grants 0..3, results routed per port
        do_reset();
        req_data  = {16'h5400, 16'h4C00, 16'h4400, 16'h3C00};
        req_valid = 4'b1111;
        for (int g = 0; g < N; g++) begin
            #1 check($sformatf("t2_grant%0d", g), 32'(req_ready), 32'(1 << g));
            step();
            req_valid[g] = 1'b0;
        end
        repeat (4) step();
        check("t2_resp_early", 32'(resp_valid), 32'h0);
        for (int g = 0; g < N; g++) begin
            logic [15:0] exp_r [4];
            exp_r = '{16'h3C00, 16'h3800, 16'h3400, 16'h3000};
            step();
            check($sformatf("t2_valid%0d", g), 32'(resp_valid), 32'((2 << g) - 1));
            check($sformatf("t2_data%0d", g), 32'(resp_data[g*W +: W]), 32'(exp_r[g]));
        end
        resp_ready = '1;
        step();
        resp_ready = '0;
        check("t2_resp_clear", 32'(resp_valid), 32'h0);
        check("t2_busy", 32'(busy), 32'h0);

        // fairness between requesters 0 and 2
        do_reset();
        req_data[15:0]  = 16'h4400;
        req_data[47:32] = 16'h5400;
        req_valid       = 4'b0101;
        resp_ready      = 4'b1111;
        gl.delete();
        for (int c = 0; c < 40; c++) begin
            #1;
            for (int i = 0; i < N; i++) if (req_ready[i]) gl.push_back(i);
            if (req_ready[1] || req_ready[3]) check("t3_stray_grant", 32'(req_ready), 32'h0);
            if (resp_valid[0]) check("t3_data0", 32'(resp_data[15:0]), 32'h3800);
            if (resp_valid[2]) check("t3_data2", 32'(resp_data[47:32]), 32'h3000);
            step();
        end
        check("t3_grant_count", 32'(gl.size() >= 6), 32'h1);
        for (int i = 0; i < 6 && i < gl.size(); i++)
            check($sformatf("t3_order%0d", i), 32'(gl[i]), 32'((i % 2) * 2));
        req_valid = '0;
        repeat (12) step();
        check("t3_busy", 32'(busy), 32'h0);

        // backpressure on requester 1
        do_reset();
        resp_ready      = 4'b1101;
        req_data[15:0]  = 16'h3C00;
        req_data[31:16] = 16'h4C00;
        req_data[63:48] = 16'h4400;
        req_valid       = 4'b0010;
        #1 check("t4_grant1", 32'(req_ready), 32'h2);
        step();
        req_valid = 4'b1011;
        repeat (8) step();
        others = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            check("t4_hold_valid", 32'(resp_valid[1]), 32'h1);
            check("t4_hold_data", 32'(resp_data[31:16]), 32'h3400);
            check("t4_no_regrant", 32'(req_ready[1]), 32'h0);
            if (req_ready[0] || req_ready[3]) others++;
            step();
        end
        check("t4_others_served", 32'(others >= 2), 32'h1);
        req_valid     = 4'b0010;
        resp_ready[1] = 1'b1;
        step();
        resp_ready[1] = 1'b0;
        #1;
        check("t4_released", 32'(resp_valid[1]), 32'h0);
        check("t4_regrant", 32'(req_ready), 32'h2);
        step();
        req_valid  = '0;
        resp_ready = '1;
        repeat (12) step();
        check("t4_busy", 32'(busy), 32'h0);

        // reset while two ops are in flight
        do_reset();
        req_data[15:0]  = 16'h3C00;
        req_data[31:16] = 16'h4400;
        req_valid       = 4'b0011;
        step();
        step();
        req_valid = '0;
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < L; c++) begin
            check("t5_resp_blank", 32'(resp_valid), 32'h0);
            check("t5_tag_err_blank", 32'(tag_err), 32'h0);
            step();
        end
        check("t5_tag_err", 32'(tag_err), 32'h0);
        check("t5_busy", 32'(busy), 32'h0);
        req_data[47:32] = 16'h5C00;
        req_valid       = 4'b0100;
        #1 check("t5_grant2", 32'(req_ready), 32'h4);
        step();
        req_valid = '0;
        repeat (8) step();
        check("t5_resp_valid", 32'(resp_valid), 32'h4);
        check("t5_resp_data", 32'(resp_data[47:32]), 32'h2C00);
        resp_ready = '1;
        step();
        resp_ready = '0;

        // spurious core output with nothing in flight
        check("t6_pre", 32'(tag_err), 32'h0);
        force_ov = 1'b1;
        step();
        force_ov = 1'b0;
        check("t6_set", 32'(tag_err), 32'h1);
        repeat (5) step();
        check("t6_sticky", 32'(tag_err), 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_cleared", 32'(tag_err), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
